// File: rtl/pipe_lane_stage.sv
// Multi-lane pipeline stage register with ready/valid handshake, per-lane clear,
// optional one-bundle skid buffer and a saturating back-pressure counter.
module pipe_lane_stage #(
    parameter int unsigned LANES         = 2,
    parameter int unsigned DW            = 64,
    parameter int unsigned SKID          = 1,
    parameter int unsigned CLEAR_YOUNGER = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [LANES-1:0]    in_valid,
    input  logic [LANES*DW-1:0] in_data,
    output logic                in_ready,
    output logic [LANES-1:0]    out_valid,
    output logic [LANES*DW-1:0] out_data,
    input  logic                out_ready,
    input  logic [LANES-1:0]    clear,
    output logic [15:0]         stall_cycles
);

    logic [LANES-1:0]    r_m_valid;
    logic [LANES*DW-1:0] r_m_data;
    logic [LANES-1:0]    r_s_valid;
    logic [LANES*DW-1:0] r_s_data;
    logic [15:0]         r_stall;

    logic [LANES-1:0]    w_clr;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_consume;
    logic [LANES-1:0]    w_m_rem_valid;
    logic [LANES-1:0]    w_s_rem_valid;
    logic [LANES-1:0]    w_in_c_valid;
    logic [LANES*DW-1:0] w_m_rem_data;
    logic [LANES*DW-1:0] w_s_rem_data;
    logic [LANES*DW-1:0] w_in_c_data;
    logic [LANES-1:0]    w_m_nxt_valid;
    logic [LANES*DW-1:0] w_m_nxt_data;
    logic [LANES-1:0]    w_s_nxt_valid;
    logic [LANES*DW-1:0] w_s_nxt_data;

    // Effective clear mask: optionally a flush of lane i also kills every younger lane.
    always_comb begin
        w_clr = clear;
        if (CLEAR_YOUNGER != 0) begin
            for (int i = 1; i < LANES; i++) begin
                w_clr[i] = w_clr[i] | w_clr[i-1];
            end
        end
    end

    always_comb begin
        if (SKID != 0) begin
            w_in_ready = ~(|r_s_valid);
        end else begin
            w_in_ready = ~(|r_m_valid) | out_ready;
        end
    end

    assign w_accept  = w_in_ready & (|in_valid);
    assign w_consume = (|r_m_valid) & out_ready;

    // Surviving contents after consume and clear; invalid lanes always carry zero data.
    always_comb begin
        w_m_rem_valid = w_consume ? '0 : (r_m_valid & ~w_clr);
        w_s_rem_valid = (SKID != 0) ? (r_s_valid & ~w_clr) : '0;
        w_in_c_valid  = w_accept ? (in_valid & ~w_clr) : '0;
        w_m_rem_data  = '0;
        w_s_rem_data  = '0;
        w_in_c_data   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_m_rem_valid[i]) w_m_rem_data[i*DW +: DW] = r_m_data[i*DW +: DW];
            if (w_s_rem_valid[i]) w_s_rem_data[i*DW +: DW] = r_s_data[i*DW +: DW];
            if (w_in_c_valid[i])  w_in_c_data[i*DW +: DW]  = in_data[i*DW +: DW];
        end
    end

    // Compact survivors in age order: M, then S, then the incoming bundle.
    always_comb begin
        w_m_nxt_valid = '0;
        w_m_nxt_data  = '0;
        w_s_nxt_valid = '0;
        w_s_nxt_data  = '0;
        if (|w_m_rem_valid) begin
            w_m_nxt_valid = w_m_rem_valid;
            w_m_nxt_data  = w_m_rem_data;
            if (|w_s_rem_valid) begin
                w_s_nxt_valid = w_s_rem_valid;
                w_s_nxt_data  = w_s_rem_data;
            end else begin
                w_s_nxt_valid = w_in_c_valid;
                w_s_nxt_data  = w_in_c_data;
            end
        end else if (|w_s_rem_valid) begin
            w_m_nxt_valid = w_s_rem_valid;
            w_m_nxt_data  = w_s_rem_data;
            w_s_nxt_valid = w_in_c_valid;
            w_s_nxt_data  = w_in_c_data;
        end else begin
            w_m_nxt_valid = w_in_c_valid;
            w_m_nxt_data  = w_in_c_data;
        end
        if (SKID == 0) begin
            w_s_nxt_valid = '0;
            w_s_nxt_data  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m_valid <= '0;
            r_m_data  <= '0;
            r_s_valid <= '0;
            r_s_data  <= '0;
            r_stall   <= '0;
        end else begin
            r_m_valid <= w_m_nxt_valid;
            r_m_data  <= w_m_nxt_data;
            r_s_valid <= w_s_nxt_valid;
            r_s_data  <= w_s_nxt_data;
            if ((|r_m_valid) && !out_ready && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_m_valid;
    assign out_data     = r_m_data;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_lane_stage.sv
// Directed self-checking bench for pipe_lane_stage: default skid configuration,
// lane-local clear variant, and a 4-lane pass-through (no skid) variant.
module tb_pipe_lane_stage;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // A: LANES=2, DW=64, SKID=1, CLEAR_YOUNGER=1
    logic [1:0]   a_in_valid;
    logic [127:0] a_in_data;
    logic         a_in_ready;
    logic [1:0]   a_out_valid;
    logic [127:0] a_out_data;
    logic         a_out_ready;
    logic [1:0]   a_clear;
    logic [15:0]  a_stall;

    // B: lane-local clear
    logic [1:0]   b_in_valid;
    logic [127:0] b_in_data;
    logic         b_in_ready;
    logic [1:0]   b_out_valid;
    logic [127:0] b_out_data;
    logic         b_out_ready;
    logic [1:0]   b_clear;
    logic [15:0]  b_stall;

    // C: LANES=4, DW=32, SKID=0
    logic [3:0]   c_in_valid;
    logic [127:0] c_in_data;
    logic         c_in_ready;
    logic [3:0]   c_out_valid;
    logic [127:0] c_out_data;
    logic         c_out_ready;
    logic [3:0]   c_clear;
    logic [15:0]  c_stall;

    pipe_lane_stage #(.LANES(2), .DW(64), .SKID(1), .CLEAR_YOUNGER(1)) u_dut_a (
        .clk(clk), .resetn(resetn), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ready(a_out_ready), .clear(a_clear), .stall_cycles(a_stall)
    );

    pipe_lane_stage #(.LANES(2), .DW(64), .SKID(1), .CLEAR_YOUNGER(0)) u_dut_b (
        .clk(clk), .resetn(resetn), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(b_out_ready), .clear(b_clear), .stall_cycles(b_stall)
    );

    pipe_lane_stage #(.LANES(4), .DW(32), .SKID(0), .CLEAR_YOUNGER(1)) u_dut_c (
        .clk(clk), .resetn(resetn), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
        .out_ready(c_out_ready), .clear(c_clear), .stall_cycles(c_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] bundle(input int id);
        logic [127:0] b;
        for (int l = 0; l < 4; l++) b[l*32 +: 32] = 32'(id * 16 + l);
        return b;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        a_in_valid = '0; a_in_data = '0; a_out_ready = 1'b0; a_clear = '0;
        b_in_valid = '0; b_in_data = '0; b_out_ready = 1'b0; b_clear = '0;
        c_in_valid = '0; c_in_data = '0; c_out_ready = 1'b0; c_clear = '0;
        #1;
        n_tests++;
        if (a_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 00", a_out_valid);
        end
        n_tests++;
        if (a_out_data !== 128'h0) begin
            n_fail++; $display("FAIL reset_out_data: got %h want 0", a_out_data);
        end
        n_tests++;
        if (a_stall !== 16'h0) begin
            n_fail++; $display("FAIL reset_stall: got %h want 0", a_stall);
        end
        #11;
        resetn = 1'b1;
        #1;
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready_a: got %b want 1", a_in_ready);
        end
        n_tests++;
        if (c_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready_c: got %b want 1", c_in_ready);
        end
    endtask

    task automatic test_basic();
        a_in_valid = 2'b11; a_in_data = {64'hB, 64'hA}; a_out_ready = 1'b1;
        tick();
        n_tests++;
        if (a_out_valid !== 2'b11) begin
            n_fail++; $display("FAIL basic_valid: got %b want 11", a_out_valid);
        end
        n_tests++;
        if (a_out_data !== {64'hB, 64'hA}) begin
            n_fail++; $display("FAIL basic_data: got %h want %h", a_out_data, {64'hB, 64'hA});
        end
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_in_ready: got %b want 1", a_in_ready);
        end
        a_in_valid = 2'b00;
        tick();
        n_tests++;
        if (a_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL basic_drain: got %b want 00", a_out_valid);
        end
    endtask

    task automatic test_skid();
        a_out_ready = 1'b0;
        a_in_valid = 2'b11; a_in_data = {64'h2, 64'h1};
        tick();
        a_in_data = {64'h4, 64'h3};
        tick();
        a_in_valid = 2'b00;
        tick();
        n_tests++;
        if (a_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL skid_full_ready: got %b want 0", a_in_ready);
        end
        n_tests++;
        if (a_out_data !== {64'h2, 64'h1}) begin
            n_fail++; $display("FAIL skid_hold_x: got %h want %h", a_out_data, {64'h2, 64'h1});
        end
        n_tests++;
        if (a_stall !== 16'd2) begin
            n_fail++; $display("FAIL skid_stall_held: got %0d want 2", a_stall);
        end
        a_out_ready = 1'b1;
        tick();
        n_tests++;
        if (a_out_data !== {64'h4, 64'h3}) begin
            n_fail++; $display("FAIL skid_y_out: got %h want %h", a_out_data, {64'h4, 64'h3});
        end
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL skid_ready_back: got %b want 1", a_in_ready);
        end
        tick();
        n_tests++;
        if (a_out_valid !== 2'b00) begin
            n_fail++; $display("FAIL skid_empty: got %b want 00", a_out_valid);
        end
        n_tests++;
        if (a_stall !== 16'd2) begin
            n_fail++; $display("FAIL skid_stall_final: got %0d want 2", a_stall);
        end
    endtask

    task automatic test_clear_younger();
        a_out_ready = 1'b0;
        a_in_valid = 2'b11; a_in_data = {64'hB1, 64'hA1};
        tick();
        a_in_valid = 2'b00; a_clear = 2'b01;
        tick();
        a_clear = 2'b00;
        n_tests++;
        if (a_out_valid !== 2'b00 || a_out_data !== 128'h0) begin
            n_fail++;
            $display("FAIL cy_clear_all: got %b/%h want 00/0", a_out_valid, a_out_data);
        end
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL cy_slot_free: got %b want 1", a_in_ready);
        end
        // lane0 stored invalid, so its data must read zero
        a_in_valid = 2'b10; a_in_data = {64'h55, 64'h99};
        tick();
        n_tests++;
        if (a_out_data !== {64'h55, 64'h0}) begin
            n_fail++; $display("FAIL cy_invalid_zero: got %h want %h", a_out_data, {64'h55, 64'h0});
        end
        a_in_valid = 2'b11; a_in_data = {64'h77, 64'h66};
        tick();
        a_in_valid = 2'b00; a_clear = 2'b10;
        tick();
        a_clear = 2'b00;
        n_tests++;
        if (a_out_valid !== 2'b01 || a_out_data !== {64'h0, 64'h66}) begin
            n_fail++;
            $display("FAIL cy_promote: got %b/%h want 01/%h", a_out_valid, a_out_data,
                     {64'h0, 64'h66});
        end
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL cy_promote_ready: got %b want 1", a_in_ready);
        end
        a_out_ready = 1'b1;
        tick();
    endtask

    task automatic test_clear_on_accept();
        a_out_ready = 1'b0;
        a_in_valid = 2'b11; a_in_data = {64'hD, 64'hC}; a_clear = 2'b10;
        tick();
        a_in_valid = 2'b00; a_clear = 2'b00;
        n_tests++;
        if (a_out_valid !== 2'b01 || a_out_data !== {64'h0, 64'hC}) begin
            n_fail++;
            $display("FAIL accept_clear: got %b/%h want 01/%h", a_out_valid, a_out_data,
                     {64'h0, 64'hC});
        end
        a_out_ready = 1'b1;
        tick();
    endtask

    task automatic test_clear_local();
        b_out_ready = 1'b0;
        b_in_valid = 2'b11; b_in_data = {64'h22, 64'h11};
        tick();
        b_in_valid = 2'b00; b_clear = 2'b01;
        tick();
        b_clear = 2'b00;
        n_tests++;
        if (b_out_valid !== 2'b10 || b_out_data !== {64'h22, 64'h0}) begin
            n_fail++;
            $display("FAIL local_clear: got %b/%h want 10/%h", b_out_valid, b_out_data,
                     {64'h22, 64'h0});
        end
    endtask

    task automatic test_no_skid();
        int or_seq[5]    = '{1, 0, 1, 0, 1};
        int in_id[5]     = '{0, 1, 1, 2, 2};
        int rdy_exp[5]   = '{1, 0, 1, 0, 1};
        int out_id[5]    = '{-1, 0, 0, 1, 1};
        c_in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            c_out_ready = or_seq[i][0];
            c_in_data   = bundle(in_id[i]);
            #1;
            n_tests++;
            if (c_in_ready !== rdy_exp[i][0]) begin
                n_fail++; $display("FAIL noskid_ready[%0d]: got %b want %0d", i, c_in_ready,
                                   rdy_exp[i]);
            end
            n_tests++;
            if (out_id[i] < 0) begin
                if (c_out_valid !== 4'b0000) begin
                    n_fail++; $display("FAIL noskid_out[%0d]: got %b want 0000", i, c_out_valid);
                end
            end else if (c_out_valid !== 4'b1111 || c_out_data !== bundle(out_id[i])) begin
                n_fail++; $display("FAIL noskid_out[%0d]: got %b/%h want 1111/%h", i,
                                   c_out_valid, c_out_data, bundle(out_id[i]));
            end
            tick();
        end
        n_tests++;
        if (c_out_valid !== 4'b1111 || c_out_data !== bundle(2)) begin
            n_fail++; $display("FAIL noskid_last: got %b/%h want 1111/%h", c_out_valid,
                               c_out_data, bundle(2));
        end
        c_in_valid = 4'b0000; c_out_ready = 1'b0;
    endtask

    task automatic test_stall_saturate();
        a_out_ready = 1'b0;
        a_in_valid = 2'b11; a_in_data = {64'hF1, 64'hF0};
        tick();
        a_in_valid = 2'b00;
        repeat (65600) @(posedge clk);
        #1;
        n_tests++;
        if (a_stall !== 16'hFFFF) begin
            n_fail++; $display("FAIL stall_saturate: got %h want ffff", a_stall);
        end
        n_tests++;
        if (a_out_valid !== 2'b11) begin
            n_fail++; $display("FAIL stall_hold: got %b want 11", a_out_valid);
        end
    endtask

    task automatic test_async_reset();
        #3;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (a_out_valid !== 2'b00 || a_out_data !== 128'h0 || a_stall !== 16'h0) begin
            n_fail++; $display("FAIL async_reset_a: got %b/%h/%h want 00/0/0", a_out_valid,
                               a_out_data, a_stall);
        end
        n_tests++;
        if (c_out_valid !== 4'b0000 || c_out_data !== 128'h0) begin
            n_fail++; $display("FAIL async_reset_c: got %b/%h want 0000/0", c_out_valid,
                               c_out_data);
        end
        #2;
        resetn = 1'b1;
        tick();
        n_tests++;
        if (a_out_valid !== 2'b00 || a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset_after: got %b/%b want 00/1", a_out_valid,
                               a_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skid();
        test_clear_younger();
        test_clear_on_accept();
        test_clear_local();
        test_no_skid();
        test_stall_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_lane_stage.md
Name: pipe_lane_stage

Overview:
- Parametrised N-lane pipeline stage register for the multi-issue datapath.
- Generalises the fixed master/slave inter-stage register to LANES issue slots with a ready/valid handshake toward the next stage.
- Carries one bundle per stage, with per-lane valid and per-lane clear (optional younger-lane flush cascade).
- Has an optional skid entry so the upstream ready signal is fully registered, plus a saturating back-pressure counter.
- Instantiated between pipeline stages (e.g. MEM→WB) in place of hand-written per-slot registers.

Parameters:
- LANES, 2, number of issue lanes; lane 0 is oldest (master).
- DW, 64, payload width per lane (caller packs control/data fields).
- SKID, 1, 1 = include one-bundle skid buffer; 0 = single register, pass-through ready.
- CLEAR_YOUNGER, 1, 1 = clear[i] also clears every lane j>i; 0 = lane-local clear only.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  LANES  per-lane valid of incoming bundle
- in_data  in  LANES*DW  lane i at [i*DW +: DW]
- in_ready  out  1  stage accepts a bundle this cycle
- out_valid  out  LANES  per-lane valid of held bundle
- out_data  out  LANES*DW  held payload; cleared/invalid lanes read 0
- out_ready  in  1  downstream consumes the bundle
- clear  in  LANES  per-lane flush request
- stall_cycles  out  16  saturating count of back-pressured cycles

Behaviour:
- Reset (resetn=0, asynchronous): all valids 0, all data 0, skid empty, stall_cycles 0; in_ready=1 once resetn is released.
- Storage: main register M (valid vector + data). When SKID=1, also skid register S.
- Bundle occupancy: a bundle is occupied when any of its lane valids is 1. out_valid = M.valid, out_data = M.data.
- Accept: occurs when in_ready=1 and |in_valid=1. The whole bundle is written; lanes with in_valid=0 are stored invalid with data 0. If in_valid is all 0, nothing is written.
- Consume: occurs when M is occupied and out_ready=1.
- in_ready, SKID=1: registered, equal to !S occupied.
- in_ready, SKID=0: combinational, equal to !M occupied | out_ready.
- SKID=1 transfers per cycle:
  - Consume, no accept: M←S (or empty); S←empty.
  - Accept with M empty, or accept together with consume and S empty: M←in.
  - Accept with M occupied and no consume: S←in. in_ready drops the next cycle.
  - Accept and consume with S occupied: impossible, because in_ready=0.
- Ordering: bundles leave in arrival order. Latency is 1 cycle from accept to out_valid when M frees.
- Clear mask: effective mask e[i] = clear[i], or, if CLEAR_YOUNGER=1, clear[k] for any k≤i.
- Clear effect: applies the same cycle to M, S, and any bundle being written that edge. Cleared lanes get valid←0 and data←0. Clear has priority over load.
- Clear empties a bundle: a bundle whose lanes all become invalid frees its slot. If S survives while M empties, S moves to M on that edge.
- Clear and consume: clear does not block consume in the same cycle. The downstream stage sees pre-edge values.
- Stall counter: increments when |out_valid & !out_ready. Saturates at 16'hFFFF. Reset only by resetn.
- Asynchronous reset mid-transfer: discards all held bundles immediately, with no partial writes.

Test Plan:
- Reset, then in_valid=2'b11 with data lane0=0xA, lane1=0xB, out_ready=1 → next cycle out_valid=11, out_data={0xB,0xA}; in_ready stays 1.
- out_ready=0 while accepting bundles X then Y (SKID=1) → X in M, Y in S, in_ready=0 on the third cycle.
  - Raise out_ready → X out, then Y out, in_ready returns to 1.
  - stall_cycles equals the number of held cycles.
- M holds 11, clear=2'b01, CLEAR_YOUNGER=1 → out_valid=00, data zero, slot freed, S promoted.
  - Same with CLEAR_YOUNGER=0 → out_valid=10, lane0 data zero.
- Accept a bundle with clear[1]=1 on the same edge → stored lane1 invalid/zero, lane0 intact.
- SKID=0, LANES=4, DW=32: continuous in_valid=1111 with out_ready toggling 1,0,1 → no drops or duplicates; in_ready follows !occupied | out_ready combinationally.
- Hold out_ready=0 for 70000 cycles with M occupied → stall_cycles=16'hFFFF.
  - Pulse resetn low mid-cycle → all outputs 0 immediately, without waiting for clk.
